// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for load-use, redirect and memory-wait hazards; define PIPE_CTRL_PERF_EN for perf counters
module pipeline_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 255,
   parameter int TO_W        = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_use_rs1,
   input  logic        id_use_rs2,
   input  logic [4:0]  ex_rd,
   input  logic        ex_mem_read,
   input  logic        ex_redirect,
   input  logic        mem_req,
   input  logic        mem_ready,
   input  logic        fault_clr,
   output logic        stall_if,
   output logic        stall_id,
   output logic        stall_ex,
   output logic        stall_mem,
   output logic        flush_id,
   output logic        flush_ex,
   output logic        flush_mem,
   output logic        flush_wb,
   output logic        mem_fault,
   output logic [31:0] perf_stall_cnt,
   output logic [31:0] perf_flush_cnt
);
   typedef enum logic [1:0] {S_RUN, S_MEM_WAIT, S_FAULT, S_RECOVER} state_t;
   state_t          state_q, state_d;
   logic [TO_W-1:0] cnt_q, cnt_d;
   logic            mem_fault_q, mem_fault_d;
   logic            load_use, hold, run_eval, purge, lu_stall;

   assign load_use = ex_mem_read && ex_rd != 5'd0 &&
                     ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
   assign hold     = state_q == S_FAULT ||
                     (!mem_ready && (state_q == S_MEM_WAIT || (state_q == S_RUN && mem_req)));
   assign run_eval = !hold && (state_q == S_RUN || state_q == S_MEM_WAIT);
   assign purge    = state_q == S_RECOVER;
   assign lu_stall = run_eval && !ex_redirect && load_use;

   assign flush_id  = purge || (run_eval && ex_redirect);
   assign flush_ex  = purge || (run_eval && (ex_redirect || load_use));
   assign flush_mem = purge;
   assign flush_wb  = purge || hold;
   assign stall_if  = hold || lu_stall;
   assign stall_id  = (hold || lu_stall) && !flush_id;
   assign stall_ex  = hold && !flush_ex;
   assign stall_mem = hold && !flush_mem;
   assign mem_fault = mem_fault_q;

   // next state and saturating wait counter
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      case (state_q)
         S_RUN: begin
            state_d = (mem_req && !mem_ready) ? S_MEM_WAIT : S_RUN;
            cnt_d   = (mem_req && !mem_ready) ? TO_W'(1) : cnt_q;
         end
         S_MEM_WAIT: begin
            state_d = mem_ready ? S_RUN : (cnt_q == TO_W'(MEM_TIMEOUT) ? S_FAULT : S_MEM_WAIT);
            cnt_d   = (!mem_ready && cnt_q != '1) ? cnt_q + TO_W'(1) : cnt_q;
         end
         S_FAULT:  state_d = fault_clr ? S_RECOVER : S_FAULT;
         default:  state_d = S_RUN;
      endcase
      mem_fault_d = state_d == S_FAULT;
   end

   // state, counter and registered fault flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_RUN;
         cnt_q       <= '0;
         mem_fault_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mem_fault_q <= mem_fault_d;
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] perf_stall_q, perf_stall_d, perf_flush_q, perf_flush_d;

   // saturating stall-cycle and flush-cycle counters
   always_comb begin
      perf_stall_d = (stall_if && perf_stall_q != '1) ? perf_stall_q + 32'd1 : perf_stall_q;
      perf_flush_d = ((flush_id || flush_ex || flush_mem || flush_wb) && perf_flush_q != '1) ?
                     perf_flush_q + 32'd1 : perf_flush_q;
   end

   // perf counter registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_stall_q <= '0;
         perf_flush_q <= '0;
      end else begin
         perf_stall_q <= perf_stall_d;
         perf_flush_q <= perf_flush_d;
      end
   end

   assign perf_stall_cnt = perf_stall_q;
   assign perf_flush_cnt = perf_flush_q;
`else
   assign perf_stall_cnt = '0;
   assign perf_flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: table vectors, corner sequences and random stimulus against a behavioural model
module tb_pipeline_hazard_ctrl;
   localparam int TO = 4;
   localparam logic [7:0] O_HOLD = 8'b1111_0001;
   localparam logic [7:0] O_REDIR = 8'b0000_1100;
   localparam logic [7:0] O_LU = 8'b1100_0100;
   localparam logic [7:0] O_PURGE = 8'b0000_1111;

   logic        clk = 1'b0, rst_n;
   logic [4:0]  id_rs1, id_rs2, ex_rd;
   logic        id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect, mem_req, mem_ready, fault_clr;
   logic        stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_mem, flush_wb;
   logic        mem_fault;
   logic [31:0] perf_stall_cnt, perf_flush_cnt;
   logic [7:0]  outs, obs;
   int          checks = 0, passed = 0;
   bit          m_fault, m_purge, m_waiting;
   int          m_run, m_stalls, m_flushes;

   typedef struct {
      logic [4:0] rs1, rs2, rd;
      logic       u1, u2, mr, rdr, mq, my;
      logic [7:0] exp;
   } vec_t;
   vec_t tbl[10];

   pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .TO_W(16)) dut (
      .clk(clk), .reset(rst_n),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
      .mem_req(mem_req), .mem_ready(mem_ready), .fault_clr(fault_clr),
      .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
      .flush_id(flush_id), .flush_ex(flush_ex), .flush_mem(flush_mem), .flush_wb(flush_wb),
      .mem_fault(mem_fault), .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
   );

   always #5 clk = ~clk;
   assign outs = {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_mem, flush_wb};

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
   endtask

   task automatic idle();
      {id_rs1, id_rs2, ex_rd} = '0;
      {id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect, mem_req, mem_ready, fault_clr} = '0;
   endtask

   task automatic model_reset();
      m_fault = 0; m_purge = 0; m_waiting = 0;
      m_run = 0; m_stalls = 0; m_flushes = 0;
   endtask

   // expected {stalls, flushes} from the hazard rules, in priority order
   function automatic logic [7:0] model_out();
      bit lu = ex_mem_read && ex_rd != 5'd0 &&
               ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
      if (m_fault) return O_HOLD;
      if (m_purge) return O_PURGE;
      if (!mem_ready && (m_waiting || mem_req)) return O_HOLD;
      if (ex_redirect) return O_REDIR;
      if (lu) return O_LU;
      return 8'h00;
   endfunction

   // called at a negedge with inputs applied; checks, then advances one clock
   task automatic step(input string nm);
      logic [7:0] exp;
      #1;
      exp = model_out();
      obs = outs;
      chk({nm, " outs"}, 32'(obs), 32'(exp));
      chk({nm, " fault"}, 32'(mem_fault), 32'(m_fault));
`ifdef PIPE_CTRL_PERF_EN
      chk({nm, " perf_stall"}, perf_stall_cnt, 32'(m_stalls));
      chk({nm, " perf_flush"}, perf_flush_cnt, 32'(m_flushes));
`else
      chk({nm, " perf_stall"}, perf_stall_cnt, 32'd0);
      chk({nm, " perf_flush"}, perf_flush_cnt, 32'd0);
`endif
      @(posedge clk);
      m_stalls += int'(exp[7]);
      if (exp[3:0] != 4'd0) m_flushes++;
      if (m_fault) begin
         if (fault_clr) begin m_fault = 0; m_purge = 1; end
      end else if (m_purge) m_purge = 0;
      else if (!mem_ready && (m_waiting || mem_req)) begin
         m_run++;
         if (m_run > TO) begin m_fault = 1; m_waiting = 0; m_run = 0; end
         else m_waiting = 1;
      end else begin
         m_waiting = 0; m_run = 0;
      end
      @(negedge clk);
   endtask

   initial begin
      tbl[0] = '{5'd0,  5'd5, 5'd5,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_LU};
      tbl[1] = '{5'd0,  5'd0, 5'd0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[2] = '{5'd0,  5'd5, 5'd5,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, O_REDIR};
      tbl[3] = '{5'd7,  5'd1, 5'd7,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[4] = '{5'd7,  5'd1, 5'd7,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, O_LU};
      tbl[5] = '{5'd7,  5'd7, 5'd7,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[6] = '{5'd3,  5'd9, 5'd9,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, O_LU};
      tbl[7] = '{5'd3,  5'd4, 5'd9,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, O_REDIR};
      tbl[8] = '{5'd3,  5'd4, 5'd9,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[9] = '{5'd31, 5'd2, 5'd31, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, O_LU};

      rst_n = 1'b0;
      idle();
      model_reset();
      #12;
      chk("reset outs", 32'(outs), 32'd0);
      chk("reset fault", 32'(mem_fault), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         idle();
         {id_rs1, id_rs2, ex_rd} = {tbl[i].rs1, tbl[i].rs2, tbl[i].rd};
         {id_use_rs1, id_use_rs2, ex_mem_read} = {tbl[i].u1, tbl[i].u2, tbl[i].mr};
         {ex_redirect, mem_req, mem_ready} = {tbl[i].rdr, tbl[i].mq, tbl[i].my};
         step($sformatf("vec%0d", i));
         chk($sformatf("vec%0d table", i), 32'(obs), 32'(tbl[i].exp));
      end

      idle();
      mem_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         ex_redirect = (i == 1);
         ex_mem_read = (i == 1); ex_rd = 5'd6; id_rs1 = 5'd6; id_use_rs1 = 1'b1;
         step("wait3");
         chk($sformatf("wait3 hold%0d", i), 32'(obs), 32'(O_HOLD));
      end
      ex_mem_read = 1'b0; mem_ready = 1'b1; ex_redirect = 1'b1;
      step("wait3 release");
      chk("wait3 release redir", 32'(obs), 32'(O_REDIR));
      idle();
      step("wait3 after");
      chk("wait3 after", 32'(obs), 32'd0);

      mem_req = 1'b1;
      for (int i = 0; i < TO + 1; i++) begin
         step("timeout");
         chk($sformatf("timeout hold%0d", i), 32'(obs), 32'(O_HOLD));
      end
      mem_req = 1'b0; mem_ready = 1'b1; ex_redirect = 1'b1;
      step("fault");
      chk("fault held outs", 32'(obs), 32'(O_HOLD));
      chk("fault raised", 32'(m_fault), 32'(1));
      idle(); fault_clr = 1'b1;
      step("fault clr");
      chk("fault clr cycle", 32'(obs), 32'(O_HOLD));
      idle();
      step("recover");
      chk("recover purge", 32'(obs), 32'(O_PURGE));
      step("post recover");
      chk("post recover", 32'(obs), 32'd0);

      mem_req = 1'b1;
      for (int i = 0; i < TO; i++) step("ready4");
      mem_ready = 1'b1;
      step("ready4 release");
      chk("ready4 release", 32'(obs), 32'd0);
      idle();
      step("ready4 no fault");
      chk("ready4 no fault", 32'(mem_fault), 32'd0);

      mem_req = 1'b1;
      for (int i = 0; i < TO + 1; i++) step("refault");
      idle();
      step("refault hold");
      rst_n = 1'b0;
      #1;
      chk("rst in fault outs", 32'(outs), 32'd0);
      chk("rst in fault mem_fault", 32'(mem_fault), 32'd0);
      chk("rst perf_stall", perf_stall_cnt, 32'd0);
      chk("rst perf_flush", perf_flush_cnt, 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 600; i++) begin
         id_rs1 = 5'($urandom_range(0, 7));
         id_rs2 = 5'($urandom_range(0, 7));
         ex_rd = 5'($urandom_range(0, 7));
         id_use_rs1 = 1'($urandom_range(0, 1));
         id_use_rs2 = 1'($urandom_range(0, 1));
         ex_mem_read = 1'($urandom_range(0, 1));
         ex_redirect = ($urandom_range(0, 3) == 0);
         mem_req = ($urandom_range(0, 2) == 0);
         mem_ready = ($urandom_range(0, 3) == 0);
         fault_clr = ($urandom_range(0, 4) == 0);
         step("rnd");
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the five-stage riscv32i pipeline. It drives the stall and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three hazard classes:
- load-use data hazards;
- EX-stage control redirects;
- multi-cycle data-memory waits, guarded by a timeout fault state.

## Interface
- MEM_TIMEOUT, 255: maximum consecutive MEM_WAIT cycles before fault; legal range 1..65535.
- TO_W, 16: width of the wait counter; must hold MEM_TIMEOUT.
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1 each  instruction in ID actually reads rs1 / rs2.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_redirect  in  1  EX resolved a taken branch or jump.
- mem_req  in  1  MEM-stage instruction is accessing data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- fault_clr  in  1  single-cycle pulse that clears the fault state.
- stall_if, stall_id, stall_ex, stall_mem  out  1 each  hold PC, IF/ID, ID/EX and EX/MEM.
- flush_id, flush_ex, flush_mem, flush_wb  out  1 each  load a bubble into IF/ID, ID/EX, EX/MEM and MEM/WB.
- mem_fault  out  1  registered; high while in S_FAULT.
- perf_stall_cnt  out  32  stall-cycle counter.
- perf_flush_cnt  out  32  flush-event counter.

## Operation
- FSM states:
  - S_RUN: reset state.
  - S_MEM_WAIT: data-memory access outstanding.
  - S_FAULT: memory timeout taken.
  - S_RECOVER: one-cycle pipeline purge.
- S_RUN, evaluated in priority order:
  - Memory wait: when mem_req=1 and mem_ready=0, assert all four stalls and flush_wb. Go to S_MEM_WAIT and load the wait counter with 1.
  - Redirect: otherwise, when ex_redirect=1, assert flush_id and flush_ex. No stalls. The redirect takes priority over load-use.
  - Load-use: otherwise, a load-use hazard exists when ex_mem_read=1, ex_rd≠0, and either (id_use_rs1 and id_rs1==ex_rd) or (id_use_rs2 and id_rs2==ex_rd). On a hazard, assert stall_if, stall_id and flush_ex for exactly one cycle.
  - Otherwise all outputs are 0.
- S_MEM_WAIT:
  - While mem_ready=0, assert all four stalls and flush_wb, and increment the counter.
  - ex_redirect and load-use detection are ignored, because EX and ID are frozen.
  - When mem_ready=1, drop all stalls that cycle and return to S_RUN. ex_redirect and load-use are then evaluated normally in that same cycle.
  - When the counter equals MEM_TIMEOUT and mem_ready=0, go to S_FAULT. If mem_ready=1 in that same cycle, ready wins and there is no fault.
- S_FAULT:
  - mem_fault=1; all stalls and flush_wb held.
  - fault_clr=1 moves the FSM to S_RECOVER. Every other input is ignored.
- S_RECOVER:
  - Assert flush_id, flush_ex, flush_mem and flush_wb with no stalls, for one cycle. Then go to S_RUN.
- Stall/flush outputs are Mealy (combinational from state and inputs). mem_fault is registered.
- When a flush and a stall target the same register, the flush wins in that register.

## Timing
- Load-use bubble costs one cycle. Redirect costs two squashed slots and zero stall cycles.
- A memory access with N wait cycles stalls the pipeline for exactly N cycles.
- A fault is raised MEM_TIMEOUT cycles after entry to S_MEM_WAIT. mem_fault rises on the next edge.
- Reset (reset=0), taking effect asynchronously:
  - State returns to S_RUN; counters cleared; mem_fault=0.
  - With idle inputs, all stall and flush outputs are 0.
  - Reset asserted mid-wait or mid-fault abandons the sequence immediately.
- The wait counter saturates and never wraps. It is reloaded on every S_RUN→S_MEM_WAIT transition.

## Configuration
- PIPE_CTRL_PERF_EN defined:
  - perf_stall_cnt increments on every cycle where stall_if=1.
  - perf_flush_cnt increments on every cycle where any flush output is 1.
  - Both counters saturate at 0xFFFFFFFF and reset to 0.
- PIPE_CTRL_PERF_EN undefined: both perf outputs are constant 0 and no counter flops are built.

## Test plan
- Load x5 in EX, ID reads rs2=x5 with id_use_rs2=1 → stall_if=stall_id=flush_ex=1 for one cycle, then all 0. Repeat with ex_rd=0 → no stall.
- ex_redirect=1 and load-use hazard in the same cycle → flush_id=flush_ex=1, stall_if=0.
- mem_req=1 with mem_ready low for 3 cycles → all stalls and flush_wb high for exactly 3 cycles, released in the cycle mem_ready=1.
- MEM_TIMEOUT=4, mem_ready never asserted → mem_fault=1 after 4 wait cycles. Pulse fault_clr → one cycle of flush_id/ex/mem/wb=1, then S_RUN.
- MEM_TIMEOUT=4, mem_ready=1 exactly on the 4th wait cycle → no fault; stalls released.
- Assert reset=0 during S_FAULT → mem_fault=0 and all outputs 0 immediately. With PIPE_CTRL_PERF_EN, check that the counters match the counted stall and flush cycles.
